// File: rtl/line_pkg.sv
// Shared constants and types for the line game: state/direction enums, head position, start/viewport defaults.
package line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_OVER,
    ST_CLEARED,
    ST_RESTART
  } state_t;

  typedef enum logic {
    DIR_RIGHT,
    DIR_UP
  } dir_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pos_t;

  localparam logic [9:0]  PROGRESS_MAX   = 10'd1000;
  localparam logic [15:0] DEF_START_X    = 16'd336;
  localparam logic [15:0] DEF_START_Y    = 16'd240;
  localparam logic [15:0] DEF_HEAD_SCR_X = 16'd320;
  localparam logic [15:0] DEF_HEAD_SCR_Y = 16'd240;

  // One movement step; both axes wrap modulo 2^16.
  function automatic pos_t pos_step(input pos_t p, input dir_t d, input logic [15:0] step);
    pos_t r;
    r = p;
    if (d == DIR_RIGHT) r.x = p.x + step;
    else                r.y = p.y - step;
    return r;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser + rising-edge pulse; btn_evt lags btn by 3 cycles.
// LINE_BTN_DEBOUNCE_EN adds a DEB_CYCLES stability filter (and DEB_CYCLES of latency).
module btn_sync_edge
`ifdef LINE_BTN_DEBOUNCE_EN
  #(parameter int DEB_CYCLES = 16)
`endif
(
  input  logic hclk,
  input  logic reset,
  input  logic btn,
  output logic btn_evt
);

  logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, evt_q, evt_d, lvl;

`ifdef LINE_BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = s2_q;
      else                              cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = s2_q;
`endif

  always_comb begin
    s1_d   = btn;
    s2_d   = s1_q;
    prev_d = lvl;
    evt_d  = lvl & ~prev_q;
  end

  // Chain resets to the pressed level: a button held through reset never yields a rising edge.
  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      evt_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign btn_evt = evt_q;

endmodule

// File: rtl/line_head_ctrl.sv
// Line head position, scroll, turn strobe, progress and game sequencing; all outputs registered.
// Optional button debounce via LINE_BTN_DEBOUNCE_EN.
module line_head_ctrl
  import line_pkg::*;
#(
  parameter logic [15:0] START_X    = DEF_START_X,
  parameter logic [15:0] START_Y    = DEF_START_Y,
  parameter logic [15:0] HEAD_SCR_X = DEF_HEAD_SCR_X,
  parameter logic [15:0] HEAD_SCR_Y = DEF_HEAD_SCR_Y,
  parameter logic [15:0] STEP       = 16'd2,
`ifdef LINE_BTN_DEBOUNCE_EN
  parameter int          DEB_CYCLES = 16,
`endif
  parameter int          TICKS_PER_PERMILLE = 12
) (
  input  logic        hclk,
  input  logic        reset,
  input  logic        btn,
  input  logic        tick,
  input  logic        crash,
  output logic [15:0] head_x,
  output logic [15:0] head_y,
  output logic [15:0] scroll_x,
  output logic [15:0] scroll_y,
  output logic        press,
  output logic [9:0]  progress,
  output logic        tips_display,
  output logic        tips_display_over,
  output logic        restart
);

  localparam logic [7:0] SUB_LAST = 8'(TICKS_PER_PERMILLE - 1);
  localparam pos_t START_POS  = '{x: START_X, y: START_Y};
  localparam pos_t START_SCRL = '{x: START_X - HEAD_SCR_X + 16'd1, y: START_Y - HEAD_SCR_Y + 16'd1};

  logic btn_evt;

  btn_sync_edge
`ifdef LINE_BTN_DEBOUNCE_EN
    #(.DEB_CYCLES(DEB_CYCLES))
`endif
  u_btn (
    .hclk    (hclk),
    .reset   (reset),
    .btn     (btn),
    .btn_evt (btn_evt)
  );

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  pos_t       head_q, head_d, scroll_q, scroll_d;
  logic [9:0] prog_q, prog_d;
  logic [7:0] sub_q, sub_d;
  logic       pend_q, pend_d, press_q, press_d, restart_q, restart_d;
  logic       tips_q, tips_d, over_q, over_d;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    head_d  = head_q;
    prog_d  = prog_q;
    sub_d   = sub_q;
    pend_d  = 1'b0;
    press_d = 1'b0;
    case (state_q)
      ST_IDLE: if (btn_evt) state_d = ST_RUN;
      ST_RUN: begin
        if (crash) begin
          state_d = ST_OVER;
        end else if (prog_q == PROGRESS_MAX) begin
          state_d = ST_CLEARED;
        end else begin
          if (pend_q) head_d = pos_step(head_d, dir_q, STEP);
          if (btn_evt) begin
            dir_d   = (dir_q == DIR_RIGHT) ? DIR_UP : DIR_RIGHT;
            press_d = 1'b1;
          end
          if (tick) begin
            // A tick coinciding with a turn is deferred one cycle so the press cycle shows the corner.
            if (btn_evt) pend_d = 1'b1;
            else         head_d = pos_step(head_d, dir_d, STEP);
            if (sub_q == SUB_LAST) begin
              sub_d = '0;
              if (prog_q != PROGRESS_MAX) prog_d = prog_q + 10'd1;
            end else begin
              sub_d = sub_q + 8'd1;
            end
          end
        end
      end
      ST_OVER, ST_CLEARED: if (btn_evt) state_d = ST_RESTART;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RESTART) begin
      head_d = START_POS;
      dir_d  = DIR_RIGHT;
      prog_d = '0;
      sub_d  = '0;
      pend_d = 1'b0;
    end

    scroll_d.x = head_d.x - HEAD_SCR_X + 16'd1;
    scroll_d.y = head_d.y - HEAD_SCR_Y + 16'd1;
    restart_d  = (state_d == ST_RESTART);
    tips_d     = (state_d == ST_IDLE);
    over_d     = (state_d == ST_OVER) || (state_d == ST_CLEARED);
  end

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_RIGHT;
      head_q    <= START_POS;
      scroll_q  <= START_SCRL;
      prog_q    <= '0;
      sub_q     <= '0;
      pend_q    <= 1'b0;
      press_q   <= 1'b0;
      restart_q <= 1'b0;
      tips_q    <= 1'b1;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      head_q    <= head_d;
      scroll_q  <= scroll_d;
      prog_q    <= prog_d;
      sub_q     <= sub_d;
      pend_q    <= pend_d;
      press_q   <= press_d;
      restart_q <= restart_d;
      tips_q    <= tips_d;
      over_q    <= over_d;
    end
  end

  assign head_x            = head_q.x;
  assign head_y            = head_q.y;
  assign scroll_x          = scroll_q.x;
  assign scroll_y          = scroll_q.y;
  assign press             = press_q;
  assign progress          = prog_q;
  assign tips_display      = tips_q;
  assign tips_display_over = over_q;
  assign restart           = restart_q;

endmodule
